// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StGap    = 2'd2
  } pulse_state_t;

  // A zero length request still produces a one-cycle pulse.
  function automatic int unsigned eff_len(input logic [31:0] len);
    if (len == '0) return 1;
    return len;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle ticks into pulses of programmable length with a minimum low gap.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: a tick while active extends the current pulse.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [LEN_W-1:0] len,
  output logic             sig,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = (LEN_W > $clog2(GAP)) ? LEN_W : $clog2(GAP);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP - 1);

  if (GAP == 0) begin : g_gap_check
    $fatal(1, "pulse_stretcher: GAP must be at least 1");
  end

  pulse_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic             sig_q, busy_q, overrun_q;
  logic             drop;

  logic [LEN_W-1:0] tick_len;
  logic [CNT_W-1:0] tick_load;
  logic [CNT_W-1:0] plen_load;

  assign tick_len  = LEN_W'(eff_len(32'(len)));
  assign tick_load = CNT_W'(tick_len) - CntOne;
  assign plen_load = CNT_W'(plen_q) - CntOne;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    plen_d  = plen_q;
    drop    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StActive;
          cnt_d   = tick_load;
        end
      end
      StActive: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        // Retrigger overrides the exit to GAP and leaves the queue alone.
        if (tick) begin
          state_d = StActive;
          cnt_d   = tick_load;
        end
`else
        if (tick) begin
          if (!pend_q) begin
            pend_d = 1'b1;
            plen_d = tick_len;
          end else begin
            drop = 1'b1;
          end
        end
`endif
      end
      StGap: begin
        if (cnt_q == '0) begin
          if (pend_q) begin
            // Pending entry starts; a coincident tick takes its place in the queue.
            state_d = StActive;
            cnt_d   = plen_load;
            pend_d  = tick;
            if (tick) plen_d = tick_len;
          end else if (tick) begin
            state_d = StActive;
            cnt_d   = tick_load;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
          if (tick) begin
            if (!pend_q) begin
              pend_d = 1'b1;
              plen_d = tick_len;
            end else begin
              drop = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      plen_q    <= '0;
      sig_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      plen_q    <= plen_d;
      sig_q     <= (state_d == StActive);
      busy_q    <= (state_d != StIdle) || pend_d;
      overrun_q <= drop;
    end
  end

  assign sig     = sig_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
